aidc_lite_decomp_rd_engine: RTL and testbench
=============================================

// Module: aidc_lite_decomp_rd_engine
// PURPOSE
//  Read DMA for the decompressor. Consumes the config block's src_addr/len/start,
//  fetches len x 64B from memory over AXI4 read (4-beat INCR bursts, 128b), buffers
//  beats in a credit-managed FIFO, streams them to the decomp core (valid/ready).
//  Drives the level done consumed by the config block's status register.
// PARAMETERS
//  FIFO_DEPTH   16   beat buffer depth; power of 2, >= 4 (one burst)
//  AXI_ID       0    constant arid value (4b)
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  src_addr_i   in   32     source byte address; [5:0] ignored (64B aligned)
//  len_i        in   26     [31:6] transfer length in 64B blocks
//  start_i      in   1      1-cycle start pulse
//  done_o       out  1      level: transfer complete
//  err_o        out  1      sticky: non-OKAY rresp seen in current transfer
//  arid_o       out  4      = AXI_ID
//  araddr_o     out  32     burst address, [5:0]=0
//  arlen_o      out  8      = 3
//  arsize_o     out  3      = 3'b100 (16B)
//  arburst_o    out  2      = INCR
//  arvalid_o    out  1
//  arready_i    in   1
//  rid_i        in   4      ignored
//  rdata_i      in   128
//  rresp_i      in   2
//  rlast_i      in   1      ignored for counting (beats counted internally)
//  rvalid_i     in   1
//  rready_o     out  1      = FIFO not full
//  data_o       out  128    stream beat to decomp core
//  valid_o      out  1      FIFO not empty
//  last_o       out  1      final beat of whole transfer
//  ready_i      in   1
// BEHAVIOUR
//  Reset (async, all regs): state=IDLE, done_o=0, err_o=0, arvalid_o=0, FIFO empty
//   (valid_o=0, rready_o=1), counters 0, credit=FIFO_DEPTH.
//  FSM IDLE -> BUSY on start_i with len_i!=0; BUSY -> IDLE when last beat popped.
//  start_i in IDLE, cycle N: latch addr={src_addr_i[31:6],6'd0}, ar_remain=len_i,
//   beat_remain=4*len_i (28b); done_o=0, err_o=0 at N+1; first arvalid_o at N+1.
//  start_i with len_i==0: no AXI traffic; done_o=1 at N+1 (set wins over clear).
//  start_i while BUSY: ignored, no state change.
//  AR: arvalid_o = BUSY & ar_remain!=0 & credit>=4. Once high, arvalid_o and
//   araddr_o stay stable until arready_i. On AR handshake: addr+=64, ar_remain-=1,
//   credit-=4. Address wraps at 2^32 silently.
//  Credit: +1 per output pop (valid_o&ready_i); simultaneous AR handshake and pop
//   gives net -3. Credit guarantees R data never back-pressured in practice.
//  R: push rdata_i on rvalid_i&rready_o. rresp_i!=OKAY -> err_o=1 (sticky),
//   data still pushed and counted; transfer completes normally.
//  Out: data_o=FIFO head, last_o=valid_o & beat_remain==1; pop decrements
//   beat_remain. Pop with last_o: done_o=1 next cycle, state=IDLE.
//  done_o holds until next accepted start_i or reset.
//  Reset mid-operation: all state cleared immediately, FIFO flushed, arvalid_o
//   drops; interconnect is reset in the same domain, no outstanding-beat recovery.
//  FIFO first-word latency: push at cycle M -> valid_o at M+1.
// STRUCTURE
//  Package aidc_lite_pkg: AXI_BURST_INCR, AXI_RESP_OKAY, BEATS_PER_BLK=4,
//   ARSIZE_16B, axi data width 128.
//  Sub-module aidc_lite_sync_fifo #(DEPTH,WIDTH=128): full/empty, async rst_n;
//   engine holds FSM, AR generator, credit and beat counters.
// TESTING
//  T1 src=0x1000_0040,len=1, ready_i=1, arready=1: 1 AR addr 0x1000_0040 arlen=3,
//   4 beats out, last_o on beat 4, done_o=1 cycle after pop.
//  T2 len=8, ready_i=0 throughout: exactly 4 ARs issued (credit 16), rready stays 1;
//   release ready_i -> remaining 4 ARs, 32 beats in order, done_o.
//  T3 len=0 start: no arvalid_o, done_o=1 next cycle; second start during BUSY of
//   len=2 run ignored (exactly 8 beats delivered).
//  T4 rresp=SLVERR on beat 2 of len=2: err_o=1 sticky, all 8 beats delivered,
//   done_o=1; next start clears err_o and done_o.
//  T5 arready held low 10 cycles: arvalid_o/araddr_o stable throughout; random
//   rvalid/ready_i gaps, len=5: data order and count (20) correct.
//  T6 rst_n asserted mid-transfer (len=4, after 2 ARs): outputs at reset values
//   immediately; fresh start len=1 completes correctly.

Source files
------------

// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the aidc_lite decompressor read path.
//  - AXI4 read encodings used by the read DMA (burst type, response, size, length)
//  - geometry of one 64B block: four 128-bit beats
//  - FSM state type of the read engine
package aidc_lite_pkg;

  localparam int          AXI_DATA_W     = 128;
  localparam int          BEATS_PER_BLK  = 4;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0]  ARSIZE_16B     = 3'b100;
  localparam logic [7:0]  ARLEN_BLK      = 8'(BEATS_PER_BLK - 1);
  localparam logic [31:0] BLK_BYTES      = 32'd64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/aidc_lite_sync_fifo.sv
// Single-clock FIFO used as the beat buffer of the read engine.
// Ports:
//  clk, rst_n       clock, asynchronous active-low reset (pointers only)
//  push_i, wdata_i  write request and data; ignored while full
//  pop_i            read request; ignored while empty
//  rdata_o          current head entry (valid whenever empty_o is low)
//  full_o, empty_o  occupancy flags
// A write in cycle M is visible at the head in cycle M+1.
module aidc_lite_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage carries no reset; a flush only has to clear the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/aidc_lite_decomp_rd_engine.sv
// Read DMA feeding the decompressor core.
// Fetches len_i x 64B starting at src_addr_i using 4-beat 128-bit AXI4 INCR
// bursts, buffers the beats and streams them out with valid/ready.
// Ports:
//  clk, rst_n               clock, asynchronous active-low reset
//  src_addr_i/len_i/start_i transfer request (address 64B aligned, length in blocks)
//  done_o, err_o            level done, sticky error for the current transfer
//  ar*                      AXI4 read address channel (constant id/len/size/burst)
//  r*                       AXI4 read data channel (rid_i and rlast_i not used)
//  data_o/valid_o/last_o    beat stream to the core, ready_i back-pressure
// Address requests are only issued when the buffer has room for the whole
// burst, so the read data channel never needs to be stalled.
module aidc_lite_decomp_rd_engine
  import aidc_lite_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           src_addr_i,
  input  logic [25:0]           len_i,
  input  logic                  start_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [3:0]            arid_o,
  output logic [31:0]           araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [3:0]            rid_i,
  input  logic [AXI_DATA_W-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [AXI_DATA_W-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e     state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [25:0]   ar_remain_q, ar_remain_d;
  logic [27:0]   beat_remain_q, beat_remain_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic fifo_full, fifo_empty;
  logic ar_fire, r_fire, pop;
  logic unused_ok;

  assign unused_ok = ^{rid_i, rlast_i};

  aidc_lite_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rvalid_i),
    .wdata_i (rdata_i),
    .pop_i   (ready_i),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rready_o  = !fifo_full;
  assign valid_o   = !fifo_empty;
  assign last_o    = valid_o && (beat_remain_q == 28'd1);
  assign arid_o    = AXI_ID;
  assign araddr_o  = addr_q;
  assign arlen_o   = ARLEN_BLK;
  assign arsize_o  = ARSIZE_16B;
  assign arburst_o = AXI_BURST_INCR;
  assign done_o    = done_q;
  assign err_o     = err_q;

  // Built from registers only; credit can only grow while a request waits,
  // so a raised request stays raised until it is accepted.
  assign arvalid_o = (state_q == ST_BUSY) && (ar_remain_q != '0) &&
                     (credit_q >= CW'(BEATS_PER_BLK));

  assign ar_fire = arvalid_o && arready_i;
  assign r_fire  = rvalid_i && rready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ar_remain_d   = ar_remain_q;
    beat_remain_d = beat_remain_q;
    done_d        = done_q;
    err_d         = err_q;
    credit_d      = credit_q + {{(CW-1){1'b0}}, pop} -
                    (ar_fire ? CW'(BEATS_PER_BLK) : CW'(0));

    if (ar_fire) begin
      addr_d      = addr_q + BLK_BYTES;
      ar_remain_d = ar_remain_q - 26'd1;
    end

    if (r_fire && (rresp_i != AXI_RESP_OKAY)) err_d = 1'b1;

    if (pop) begin
      beat_remain_d = beat_remain_q - 28'd1;
      if (last_o) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if ((state_q == ST_IDLE) && start_i) begin
      err_d = 1'b0;
      if (len_i == '0) begin
        done_d = 1'b1;
      end else begin
        done_d        = 1'b0;
        state_d       = ST_BUSY;
        addr_d        = {src_addr_i[31:6], 6'd0};
        ar_remain_d   = len_i;
        beat_remain_d = {len_i, 2'b00};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      ar_remain_q   <= '0;
      beat_remain_q <= '0;
      credit_q      <= CW'(FIFO_DEPTH);
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ar_remain_q   <= ar_remain_d;
      beat_remain_q <= beat_remain_d;
      credit_q      <= credit_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_aidc_lite_decomp_rd_engine.sv
// Bench for the decompressor read engine. An AXI read slave model returns a
// known pattern per address/beat; expected beats and burst addresses are
// queued when a start is issued and checked by independent monitors.
module tb_aidc_lite_decomp_rd_engine;

  logic         clk;
  logic         rst_n;
  logic [31:0]  src_addr_i;
  logic [25:0]  len_i;
  logic         start_i;
  logic         done_o, err_o;
  logic [3:0]   arid_o;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic [2:0]   arsize_o;
  logic [1:0]   arburst_o;
  logic         arvalid_o, arready_i;
  logic [3:0]   rid_i;
  logic [127:0] rdata_i;
  logic [1:0]   rresp_i;
  logic         rlast_i, rvalid_i, rready_o;
  logic [127:0] data_o;
  logic         valid_o, last_o, ready_i;

  aidc_lite_decomp_rd_engine #(.FIFO_DEPTH(16), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .src_addr_i(src_addr_i), .len_i(len_i), .start_i(start_i),
    .done_o(done_o), .err_o(err_o), .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [127:0] data; logic last; } beat_t;

  int          errors = 0;
  int          checks = 0;
  beat_t       exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] burst_q[$];
  int          ar_count = 0;
  int          pop_count = 0;
  int          r_stall = 0;
  int          ready_mode = 0;   // 0 always high, 1 always low, 2 random
  int          ar_hold = 0;      // cycles to keep arready low
  bit          r_gaps = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          err_beat = -1;

  function automatic logic [127:0] pat(input logic [31:0] a, input int k);
    return {a, 32'(k), ~a, 32'hA5A5_0000 | 32'(k)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Ready driver for the stream output.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'b0;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // AR acceptor and address-channel monitor.
  initial begin
    logic [31:0] ea;
    arready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready_i = 1'b0;
        exp_ar_q.delete();
        continue;
      end
      arready_i = (ar_hold > 0) ? 1'b0 : 1'b1;
      if (ar_hold > 0) ar_hold--;
      #1;
      if (rst_n && arvalid_o && arready_i) begin
        ar_count++;
        if (exp_ar_q.size() == 0) begin
          check("ar_unexpected", 128'(araddr_o), 128'hDEAD);
        end else begin
          ea = exp_ar_q.pop_front();
          check("ar_addr", 128'(araddr_o), 128'(ea));
          check("ar_ctrl", 128'({arid_o, arlen_o, arsize_o, arburst_o}),
                128'({4'h0, 8'd3, 3'b100, 2'b01}));
        end
        burst_q.push_back(araddr_o);
      end
    end
  end

  // R channel slave model.
  initial begin
    int  beat = 0;
    bit  r_hs = 0;
    rvalid_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0; rid_i = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        burst_q.delete();
        beat = 0; r_hs = 0; rvalid_i = 1'b0;
        continue;
      end
      if (r_hs) begin
        beat++;
        if (beat == 4) begin
          void'(burst_q.pop_front());
          beat = 0;
        end
        rvalid_i = 1'b0;
      end
      if (!rvalid_i && burst_q.size() > 0 && !(r_gaps && $urandom_range(0, 2) == 0)) begin
        rdata_i  = pat(burst_q[0] + 32'(beat * 16), beat);
        rresp_i  = (burst_q[0] == err_addr && beat == err_beat) ? 2'b10 : 2'b00;
        rlast_i  = (beat == 3);
        rvalid_i = 1'b1;
      end
      #1;
      r_hs = rvalid_i && rready_o && rst_n;
      if (rst_n && rvalid_i && !rready_o) r_stall++;
    end
  end

  // Output stream monitor.
  initial begin
    bit    done_pend = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        done_pend = 0;
        continue;
      end
      if (done_pend) begin
        check("done_after_last", 128'(done_o), 128'(1));
        done_pend = 0;
      end
      if (valid_o && ready_i) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", data_o, 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", data_o, e.data);
          check("beat_last", 128'(last_o), 128'(e.last));
          if (e.last) done_pend = 1;
        end
      end
    end
  end

  // Caller sits just after a negedge; returns one cycle later (cycle N+1).
  task automatic pulse_start(input logic [31:0] src, input logic [25:0] len, input bit accept);
    logic [31:0] base, a;
    base = {src[31:6], 6'd0};
    if (accept) begin
      for (int b = 0; b < int'(len); b++) begin
        a = base + 32'(b * 64);
        exp_ar_q.push_back(a);
        for (int k = 0; k < 4; k++)
          exp_q.push_back('{data: pat(a + 32'(k * 16), k), last: (b == int'(len) - 1) && (k == 3)});
      end
    end
    src_addr_i = src; len_i = len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 128'(done_o), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, pc0;
    rst_n = 1'b0; start_i = 1'b0; src_addr_i = '0; len_i = '0;
    repeat (2) @(negedge clk);
    check("rst_done",    128'(done_o),    128'(0));
    check("rst_err",     128'(err_o),     128'(0));
    check("rst_arvalid", 128'(arvalid_o), 128'(0));
    check("rst_valid",   128'(valid_o),   128'(0));
    check("rst_rready",  128'(rready_o),  128'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single block
    pulse_start(32'h1000_0040, 26'd1, 1);
    check("t1_done_clr", 128'(done_o),    128'(0));
    check("t1_arvalid",  128'(arvalid_o), 128'(1));
    check("t1_araddr",   128'(araddr_o),  128'(32'h1000_0040));
    wait_done("t1_done", 100);

    // T2: output stalled, credit limits outstanding bursts
    ready_mode = 1;
    ar_count = 0;
    @(negedge clk);
    pulse_start(32'h2000_0000, 26'd8, 1);
    repeat (40) @(negedge clk);
    check("t2_ar_credit_limit", 128'(ar_count), 128'(4));
    check("t2_no_r_stall", 128'(r_stall), 128'(0));
    check("t2_done_low", 128'(done_o), 128'(0));
    ready_mode = 0;
    wait_done("t2_done", 300);
    check("t2_ar_total", 128'(ar_count), 128'(8));

    // T3: zero length, then start ignored while busy
    @(negedge clk);
    pulse_start(32'h3000_0000, 26'd0, 0);
    check("t3_len0_arvalid", 128'(arvalid_o), 128'(0));
    check("t3_len0_done",    128'(done_o),    128'(1));
    pc0 = pop_count;
    pulse_start(32'h3000_0080, 26'd2, 1);
    check("t3_done_clr", 128'(done_o), 128'(0));
    pulse_start(32'h3FFF_FFC0, 26'd3, 0);
    wait_done("t3_done", 200);
    repeat (8) @(negedge clk);
    check("t3_beats", 128'(pop_count - pc0), 128'(8));

    // T4: SLVERR on second beat of the transfer
    err_addr = 32'h4000_0000; err_beat = 1;
    pulse_start(32'h4000_0000, 26'd2, 1);
    check("t4_err_clear_at_start", 128'(err_o), 128'(0));
    wait_done("t4_done", 200);
    check("t4_err_sticky", 128'(err_o), 128'(1));
    err_addr = 32'hFFFF_FFFF; err_beat = -1;
    pulse_start(32'h4100_0000, 26'd1, 1);
    check("t4_restart_err", 128'(err_o),  128'(0));
    check("t4_restart_done", 128'(done_o), 128'(0));
    wait_done("t4_done2", 200);

    // T5: arready held low, random gaps, address wrap
    ar_hold = 14;
    @(negedge clk);
    pulse_start(32'hFFFF_FF80, 26'd5, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(arvalid_o === 1'b1 && araddr_o === 32'hFFFF_FF80)) bad++;
      @(negedge clk);
    end
    check("t5_ar_stable", 128'(bad), 128'(0));
    ready_mode = 2; r_gaps = 1;
    pc0 = pop_count;
    wait_done("t5_done", 2000);
    check("t5_beats", 128'(pop_count - pc0), 128'(20));
    ready_mode = 0; r_gaps = 0;

    // T6: reset in the middle of a transfer
    @(negedge clk);
    ar_count = 0;
    pulse_start(32'h6000_0000, 26'd4, 1);
    for (int i = 0; i < 50 && ar_count < 2; i++) @(negedge clk);
    check("t6_two_ars", 128'(ar_count >= 2), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_arvalid", 128'(arvalid_o), 128'(0));
    check("t6_rst_valid",   128'(valid_o),   128'(0));
    check("t6_rst_rready",  128'(rready_o),  128'(1));
    check("t6_rst_done",    128'(done_o),    128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(32'h7000_0000, 26'd1, 1);
    wait_done("t6_done", 100);

    repeat (4) @(negedge clk);
    check("end_beats_pending", 128'(exp_q.size()), 128'(0));
    check("end_ars_pending",   128'(exp_ar_q.size()), 128'(0));
    check("end_r_stall",       128'(r_stall), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
